// File: rtl/act_unit.sv
// act_unit: multi-lane activation stage (bypass/ReLU/clamp/leaky) with skid buffer.
// Define ACT_ZCNT_EN to build the saturating zero-lane counter.
module act_unit #(
  parameter int DATA_W     = 8,
  parameter int LANES      = 4,
  parameter int CLAMP_MAX  = 96,
  parameter int LEAK_SHIFT = 3,
  parameter int ZCNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  input  logic                    zcnt_clr,
  output logic [ZCNT_W-1:0]       zcnt
);

  localparam int BW = LANES * DATA_W;
  localparam logic signed [DATA_W-1:0] LP_CMAX = DATA_W'(CLAMP_MAX);

  function automatic logic [DATA_W-1:0] f_act(
    input logic [1:0]               m,
    input logic signed [DATA_W-1:0] x
  );
    logic [DATA_W-1:0] y;
    unique case (m)
      2'b00: y = x;
      2'b01: y = x[DATA_W-1] ? '0 : x;
      2'b10: y = x[DATA_W-1] ? '0 :
                 (x > LP_CMAX) ? LP_CMAX : x;
      2'b11: y = x[DATA_W-1] ? (x >>> LEAK_SHIFT) : x;
      default: y = x;
    endcase
    return y;
  endfunction

  logic [BW-1:0] w_act;
  logic [BW-1:0] r_or_d;
  logic [BW-1:0] r_sk_d;
  logic          r_or_v;
  logic          r_sk_v;
  logic          w_acc;
  logic          w_rel;

  always_comb begin
    w_act = '0;
    for (int i = 0; i < LANES; i++) begin
      w_act[i*DATA_W +: DATA_W] =
        f_act(mode, in_data[i*DATA_W +: DATA_W]);
    end
  end

  assign in_ready  = reset & ~r_sk_v;
  assign out_valid = r_or_v;
  assign out_data  = r_or_d;
  assign w_acc     = in_valid & in_ready;
  assign w_rel     = r_or_v & out_ready;

  // An accept implies SK is empty, so SK->OR and accept->OR never collide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_or_d <= '0;
      r_or_v <= 1'b0;
      r_sk_d <= '0;
      r_sk_v <= 1'b0;
    end else begin
      if (w_acc && (!r_or_v || w_rel)) begin
        r_or_d <= w_act;
        r_or_v <= 1'b1;
      end else if (w_rel && r_sk_v) begin
        r_or_d <= r_sk_d;
        r_sk_v <= 1'b0;
      end else if (w_rel) begin
        r_or_v <= 1'b0;
      end
      if (w_acc && r_or_v && !w_rel) begin
        r_sk_d <= w_act;
        r_sk_v <= 1'b1;
      end
    end
  end

`ifdef ACT_ZCNT_EN
  localparam int CW = $clog2(LANES + 1);

  logic [CW-1:0]     w_zl;
  logic [ZCNT_W:0]   w_sum;
  logic [ZCNT_W-1:0] w_zinc;
  logic [ZCNT_W-1:0] r_zcnt;

  always_comb begin
    w_zl = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_or_d[i*DATA_W +: DATA_W] == '0)
        w_zl = w_zl + CW'(1);
    end
  end

  assign w_sum  = {1'b0, r_zcnt} + (ZCNT_W+1)'(w_zl);
  assign w_zinc = w_sum[ZCNT_W] ? '1 : w_sum[ZCNT_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_zcnt <= '0;
    end else if (zcnt_clr) begin
      r_zcnt <= w_rel ? ZCNT_W'(w_zl) : '0;
    end else if (w_rel) begin
      r_zcnt <= w_zinc;
    end
  end

  assign zcnt = r_zcnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = zcnt_clr;
  assign zcnt         = '0;
`endif

endmodule

// File: doc/act_unit.md
# act_unit

Parametrised, multi-lane activation stage that sits between the PE array output and the max-pool/writeback path. It accepts a beat of LANES signed activations per cycle and applies a selectable function: bypass, ReLU, clamped ReLU, or leaky ReLU. The result is registered, with a 1-cycle latency. Full-throughput valid/ready flow control uses an internal skid buffer, so back-pressure from the pooling stage never drops or duplicates data.

## Interface
Parameters:
- DATA_W, 8, width of one signed two's-complement lane
- LANES, 4, lanes processed per beat
- CLAMP_MAX, 96, upper bound for clamped ReLU; 6.0 in Q4.4; must satisfy 0 < CLAMP_MAX <= 2^(DATA_W-1)-1
- LEAK_SHIFT, 3, arithmetic right-shift applied to negative inputs in leaky mode; range 1..DATA_W-1
- ZCNT_W, 16, width of the zero-lane counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- mode  in  2  activation select, sampled with each accepted beat: 00 bypass, 01 ReLU, 10 clamped ReLU, 11 leaky ReLU
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat
- in_data  in  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  LANES*DATA_W  activated lanes, same packing as in_data
- zcnt_clr  in  1  synchronous clear of zcnt
- zcnt  out  ZCNT_W  saturating count of zero-valued output lanes

## Operation
- Per-lane function, with x signed:
  - Bypass: y = x.
  - ReLU: y = (x < 0) ? 0 : x.
  - Clamp: y = 0 if x < 0; CLAMP_MAX if x > CLAMP_MAX; otherwise x.
  - Leaky: y = x if x >= 0; otherwise x >>> LEAK_SHIFT (floor rounding, so -1 maps to -1 and -8 maps to -1 with shift 3).
- No result exceeds DATA_W bits, so no overflow is possible.
- Lanes are independent. mode is captured together with in_data on accept, so a mode change between beats takes effect exactly at the beat boundary.
- Storage is an output register (OR) plus one skid register (SK). Each holds data and a valid bit.
- Accept is in_valid && in_ready. Release is out_valid && out_ready.
- On accept, with OR empty or releasing, the computed lanes load into OR. Otherwise they load into SK.
- On release with SK valid, SK moves into OR and SK empties.
- Order is strictly preserved, with no drops and no duplicates.
- The activation function is computed before registering, so SK holds already-activated data.

## Timing
- Latency: accept at edge N gives out_valid = 1 after edge N when OR was empty or releasing.
- Throughput: 1 beat per cycle while out_ready = 1.
- in_ready = reset && !SK.valid. It depends only on flops and reset, never combinationally on out_ready.
- With out_ready = 0 the unit absorbs 2 beats (OR, SK), then deasserts in_ready the cycle after the second accept.
- Simultaneous accept and release with SK empty: OR reloads with the new beat and out_valid stays 1.
- Output stability: out_data and out_valid hold while out_valid = 1 && out_ready = 0.
- Reset assertion (asynchronous, any cycle including mid-stream):
  - OR.valid = 0, SK.valid = 0, out_data = 0, zcnt = 0, in_ready = 0.
  - In-flight beats are discarded.
- First accept is possible on the first rising edge after reset deasserts.
- zcnt increments by the number of zero lanes in each released beat, saturating at 2^ZCNT_W-1.
- If zcnt_clr coincides with a release, zcnt loads that beat's zero-lane count.

## Configuration
- `ACT_ZCNT_EN` defined: the zero-lane counter is built as described.
- Not defined: the counter logic is removed, zcnt is tied to 0, and zcnt_clr is ignored. The datapath and handshakes are identical in both builds.

## Test plan
- ReLU sweep: mode 01, lanes {0x85, 0xFF, 0x00, 0x7F} -> out {0x00, 0x00, 0x00, 0x7F} one cycle after accept; zcnt = 3.
- Clamp/leaky: mode 10 on {0x70, 0x60, 0xF0, 0x10} -> {0x60, 0x60, 0x00, 0x10}; mode 11 on {0xF8, 0xFF, 0x80, 0x05} -> {0xFF, 0xFF, 0xF0, 0x05}.
- Back-pressure: stream 6 beats with incrementing values, out_ready low for cycles 2-5.
  - in_ready falls after the 2nd stalled accept.
  - Output sequence is exact, in order, with no gaps once out_ready returns.
- Per-beat mode switch: alternate modes 00/01 on the same data 0x81 -> outputs alternate 0x81/0x00.
- Reset mid-stream: assert reset while OR and SK are full -> out_valid = 0, in_ready = 0, zcnt = 0 immediately; post-reset beat passes with 1-cycle latency.
- Counter saturation (`ACT_ZCNT_EN`, ZCNT_W = 4): 5 all-zero beats -> zcnt = 15; zcnt_clr with a 2-zero release -> zcnt = 2.
